// File: rtl/div_recon_mul.sv
// div_recon_mul -- rebuilds a dividend from quotient, divisor and remainder:
//    x = q*y + r
// using an iterative shift-add datapath behind valid/ready handshakes.
//
// Parameters:
//    W          operand width; result is 2W bits
//    SKIP_ZERO  1 = leave CALC as soon as the remaining quotient bits are all
//               zero; 0 = always W compute cycles
//
// Ports:
//    clk        rising-edge clock
//    rst        synchronous active-high reset
//    in_valid   operand set valid
//    in_ready   block can accept operands (IDLE and not in reset)
//    q, y, r    quotient, divisor, remainder (sampled on the accept edge only)
//    out_valid  result valid (held in DONE until out_ready)
//    out_ready  downstream accepts result
//    x          reconstructed dividend
//
// Optional feature, macro DIV_RECON_CHECK_EN:
//    x_ref      original dividend, captured on the accept edge
//    mismatch   x != x_ref, valid with out_valid
//    err_mag    |x - x_ref|, valid with out_valid
module div_recon_mul #(
   parameter int W         = 8,
   parameter int SKIP_ZERO = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   q,
   input  logic [W-1:0]   y,
   input  logic [W-1:0]   r,
`ifdef DIV_RECON_CHECK_EN
   input  logic [2*W-1:0] x_ref,
   output logic           mismatch,
   output logic [2*W-1:0] err_mag,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] x
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} st_t;

   st_t            state, state_nxt;
   logic [2*W-1:0] acc, acc_nxt;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   qsh;
   logic [CW-1:0]  cnt;
   logic           accept;
   logic           calc_end;

   // in_ready is also gated by rst so it reads 0 during the reset cycle.
   assign in_ready  = (state == IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign x         = acc;

   // Sum can never exceed 2^2W-1, so the 2W-bit add has no carry-out.
   always_comb begin
      acc_nxt  = acc;
      if (qsh[0])
         acc_nxt = acc + mcand;
      calc_end = (cnt == CNT_LAST);
      // Remaining multiplier bits all zero: further cycles add nothing.
      if (SKIP_ZERO != 0 && (qsh >> 1) == '0)
         calc_end = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = CALC;
         CALC:    if (calc_end)  state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         mcand <= '0;
         qsh   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  acc   <= {{W{1'b0}}, r};
                  mcand <= {{W{1'b0}}, y};
                  qsh   <= q;
                  cnt   <= '0;
               end
            end
            CALC: begin
               acc   <= acc_nxt;
               mcand <= mcand << 1;
               qsh   <= qsh >> 1;
               cnt   <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef DIV_RECON_CHECK_EN
   logic [2*W-1:0] xref_q;

   // Compare against the final sum on the CALC->DONE edge so the flags
   // appear together with out_valid and stay put through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         xref_q   <= '0;
         mismatch <= 1'b0;
         err_mag  <= '0;
      end else begin
         if (accept)
            xref_q <= x_ref;
         if (state == CALC && calc_end) begin
            mismatch <= (acc_nxt != xref_q);
            err_mag  <= (acc_nxt >= xref_q) ? (acc_nxt - xref_q)
                                             : (xref_q - acc_nxt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_div_recon_mul.sv
// Directed bench for div_recon_mul: instance 0 is SKIP_ZERO=0, instance 1 is
// SKIP_ZERO=1. Operand buses are shared; handshakes are per instance.
module tb_div_recon_mul;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   q, y, r;
   logic [1:0]     iv, ir, ov, ordy;
   logic [2*W-1:0] x0, x1;
   int             n_run = 0;
   int             n_fail = 0;
`ifdef DIV_RECON_CHECK_EN
   logic [2*W-1:0] x_ref;
   logic [1:0]     mm;
   logic [2*W-1:0] em0, em1;
`endif

   always #5 clk = ~clk;

   div_recon_mul #(.W(W), .SKIP_ZERO(0)) u_fix (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .q(q), .y(y), .r(r),
`ifdef DIV_RECON_CHECK_EN
      .x_ref(x_ref), .mismatch(mm[0]), .err_mag(em0),
`endif
      .out_valid(ov[0]), .out_ready(ordy[0]), .x(x0));

   div_recon_mul #(.W(W), .SKIP_ZERO(1)) u_skip (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .q(q), .y(y), .r(r),
`ifdef DIV_RECON_CHECK_EN
      .x_ref(x_ref), .mismatch(mm[1]), .err_mag(em1),
`endif
      .out_valid(ov[1]), .out_ready(ordy[1]), .x(x1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] xsel(input int s);
      return (s != 0) ? x1 : x0;
   endfunction

   // Accept one operand set on instance s, measure latency (accept cycle
   // counts as 1), check x; optionally complete the output handshake.
   task automatic op(input int s, input logic [W-1:0] qq, yy, rr,
                     input logic [2*W-1:0] ex, input int el,
                     input string tag, input bit hs);
      int lat;
      q = qq; y = yy; r = rr; iv[s] = 1'b1;
      @(posedge clk); #1;
      iv[s] = 1'b0;
      q = W'($urandom); y = W'($urandom); r = W'($urandom);
      lat = 1;
      while (!ov[s] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, el);
      chk({tag, "_x"}, 32'(xsel(s)), 32'(ex));
      if (hs) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit seen;
      rst = 1'b1; iv = '0; ordy = 2'b11; q = '0; y = '0; r = '0;
`ifdef DIV_RECON_CHECK_EN
      x_ref = '0;
`endif
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(ir), 32'h0);
      chk("rst_out_valid", 32'(ov), 32'h0);
      chk("rst_x0", 32'(x0), 32'h0);
      chk("rst_x1", 32'(x1), 32'h0);
      rst = 1'b0; #1;
      chk("post_rst_in_ready", 32'(ir), 32'h3);

      op(0, 8'h05, 8'h03, 8'h01, 16'h0010, 9, "fix_5x3p1", 1'b1);
      op(0, 8'hFF, 8'hFF, 8'hFE, 16'hFEFF, 9, "fix_max", 1'b1);
      op(1, 8'hFF, 8'hFF, 8'hFE, 16'hFEFF, 9, "skip_max", 1'b1);
      op(1, 8'h01, 8'h80, 8'h00, 16'h0080, 2, "skip_q1", 1'b1);
      op(1, 8'h00, 8'h33, 8'h7F, 16'h007F, 2, "skip_q0", 1'b1);
      op(1, 8'h05, 8'h03, 8'h01, 16'h0010, 4, "skip_5x3p1", 1'b1);
      op(0, 8'h00, 8'h33, 8'h7F, 16'h007F, 9, "fix_q0", 1'b1);

      // Backpressure in DONE with in_valid high and changing q.
      ordy[0] = 1'b0;
      op(0, 8'h05, 8'h03, 8'h01, 16'h0010, 9, "bp_op", 1'b0);
      for (int i = 0; i < 5; i++) begin
         iv[0] = 1'b1; q = W'(8'h40 + i);
         @(posedge clk); #1;
         chk("bp_x", 32'(x0), 32'h0010);
         chk("bp_in_ready", 32'(ir[0]), 32'h0);
         chk("bp_out_valid", 32'(ov[0]), 32'h1);
      end
      iv[0] = 1'b0; ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_ov", 32'(ov[0]), 32'h0);
      chk("bp_release_ir", 32'(ir[0]), 32'h1);
      op(0, 8'h01, 8'h80, 8'h00, 16'h0080, 9, "bp_next", 1'b1);

      // Reset during the 4th CALC cycle.
      q = 8'hAA; y = 8'h55; r = 8'h00; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_ov", 32'(ov[0]), 32'h0);
      rst = 1'b0; #1;
      chk("abort_ir", 32'(ir[0]), 32'h1);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (ov[0]) seen = 1'b1;
      end
      chk("abort_no_ov", 32'(seen), 32'h0);
      op(0, 8'h02, 8'h07, 8'h03, 16'h0011, 9, "after_abort", 1'b1);

`ifdef DIV_RECON_CHECK_EN
      x_ref = 16'h0011;
      op(0, 8'h05, 8'h03, 8'h01, 16'h0010, 9, "chk_bad", 1'b0);
      chk("chk_bad_mm", 32'(mm[0]), 32'h1);
      chk("chk_bad_err", 32'(em0), 32'h1);
      @(posedge clk); #1;
      x_ref = 16'h0010;
      op(0, 8'h05, 8'h03, 8'h01, 16'h0010, 9, "chk_ok", 1'b0);
      chk("chk_ok_mm", 32'(mm[0]), 32'h0);
      chk("chk_ok_err", 32'(em0), 32'h0);
      @(posedge clk); #1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
